// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data-memory access, lane steering, MEM/WB register.
// Optional misaligned-access exception port guarded by MISALIGN_EXC_EN.
module mem_access_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidM,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       WriteDataM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic                  MemToRegM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    output logic                  StallM,
    output logic                  DmemReqValid,
    input  logic                  DmemReqReady,
    output logic [XLEN-1:0]       DmemAddr,
    output logic                  DmemWe,
    output logic [XLEN-1:0]       DmemWdata,
    output logic [3:0]            DmemWstrb,
    input  logic                  DmemRspValid,
    input  logic [XLEN-1:0]       DmemRdata,
    output logic                  ValidW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       ALUResultW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  RegWriteW,
    output logic                  MemToRegW
`ifdef MISALIGN_EXC_EN
    ,
    output logic                  MisalignExcW
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic            we_q;
    logic [2:0]      funct3_q;

    logic            mem_op;
    logic            mis_exc;
    logic            issue;
    logic            complete;
    logic [XLEN-1:0] st_data;
    logic [3:0]      st_strb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign mem_op = ValidM & (MemReadM | MemWriteM);

`ifdef MISALIGN_EXC_EN
    logic misalign_m;
    // Funct3[1:0]: 00 byte, 01 half, 1x word (unknown encodings fall to word)
    assign misalign_m = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                        (Funct3M[1] & (|ALUResultM[1:0]));
    assign mis_exc    = mem_op & misalign_m;
`else
    assign mis_exc    = 1'b0;
`endif

    assign issue = mem_op & ~mis_exc;

    always_comb begin
        st_data = WriteDataM;
        st_strb = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                st_data = {4{WriteDataM[7:0]}};
                st_strb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                st_data = {2{WriteDataM[15:0]}};
                st_strb = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = DmemRdata[7:0];
        case (addr_q[1:0])
            2'b01:   ld_byte = DmemRdata[15:8];
            2'b10:   ld_byte = DmemRdata[23:16];
            2'b11:   ld_byte = DmemRdata[31:24];
            default: ;
        endcase
        ld_half = addr_q[1] ? DmemRdata[31:16] : DmemRdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = DmemRdata;
        endcase
    end

    always_comb begin
        state_nx     = state;
        StallM       = 1'b0;
        DmemReqValid = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nx = REQ;
                    StallM   = 1'b1;
                end
            end
            REQ: begin
                DmemReqValid = 1'b1;
                // a store retires on the handshake cycle, a load still waits for data
                StallM = ~(DmemReqReady & we_q);
                if (DmemReqReady) state_nx = we_q ? IDLE : RESP;
            end
            RESP: begin
                StallM = ~DmemRspValid;
                if (DmemRspValid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign complete  = ~StallM & ((state != IDLE) | ValidM);
    assign DmemAddr  = {addr_q[XLEN-1:2], 2'b00};
    assign DmemWe    = we_q;
    assign DmemWdata = wdata_q;
    assign DmemWstrb = wstrb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            ValidW     <= 1'b0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            MemToRegW  <= 1'b0;
`ifdef MISALIGN_EXC_EN
            MisalignExcW <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if ((state == IDLE) && issue) begin
                // a load wins when both read and write are asserted
                addr_q   <= ALUResultM;
                we_q     <= ~MemReadM;
                wdata_q  <= MemReadM ? '0 : st_data;
                wstrb_q  <= MemReadM ? 4'b0000 : st_strb;
                funct3_q <= Funct3M;
            end
            if (complete) begin
                ValidW     <= 1'b1;
                ALUResultW <= (state == IDLE) ? ALUResultM : addr_q;
                RdW        <= RdM;
                RegWriteW  <= RegWriteM & (state != REQ) & ~mis_exc;
                MemToRegW  <= MemToRegM;
                ReadDataW  <= (state == RESP) ? ld_data : '0;
`ifdef MISALIGN_EXC_EN
                MisalignExcW <= mis_exc;
`endif
            end else begin
                ValidW    <= 1'b0;
                RegWriteW <= 1'b0;
`ifdef MISALIGN_EXC_EN
                MisalignExcW <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, MemToRegM, MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;
    logic [2:0]  Funct3M;
    logic        StallM, DmemReqValid, DmemReqReady, DmemWe, DmemRspValid;
    logic [31:0] DmemAddr, DmemWdata, DmemRdata;
    logic [3:0]  DmemWstrb;
    logic        ValidW, RegWriteW, MemToRegW;
    logic [31:0] ReadDataW, ALUResultW;
    logic [4:0]  RdW;
`ifdef MISALIGN_EXC_EN
    logic        MisalignExcW;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ValidM(ValidM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemReadM(MemReadM),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .StallM(StallM),
        .DmemReqValid(DmemReqValid), .DmemReqReady(DmemReqReady), .DmemAddr(DmemAddr),
        .DmemWe(DmemWe), .DmemWdata(DmemWdata), .DmemWstrb(DmemWstrb),
        .DmemRspValid(DmemRspValid), .DmemRdata(DmemRdata),
        .ValidW(ValidW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .RdW(RdW),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW)
`ifdef MISALIGN_EXC_EN
        , .MisalignExcW(MisalignExcW)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ValidM = 1'b0; ALUResultM = '0; WriteDataM = '0; RdM = '0;
        RegWriteM = 1'b0; MemToRegM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        Funct3M = '0;
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [2:0] f3);
        ValidM = 1'b1; ALUResultM = a; WriteDataM = 32'h5555_5555; RdM = 5'd7;
        RegWriteM = 1'b1; MemToRegM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0;
        Funct3M = f3;
    endtask

    // accept immediately; response arrives gap cycles after the accept cycle
    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] rdata, input int gap, input logic [31:0] exp);
        @(posedge clk); #1;
        drive_load(a, f3);
        DmemReqReady = 1'b1;
        @(negedge clk);
        check({tag, "_stall_idle"}, StallM, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_reqvalid"}, DmemReqValid, 1);
        check({tag, "_addr"}, DmemAddr, {a[31:2], 2'b00});
        check({tag, "_stall_req"}, StallM, 1);
        @(posedge clk); #1;
        DmemReqReady = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            check({tag, "_stall_resp"}, StallM, 1);
            @(posedge clk); #1;
        end
        DmemRspValid = 1'b1;
        DmemRdata    = rdata;
        @(negedge clk);
        check({tag, "_stall_done"}, StallM, 0);
        @(posedge clk); #1;
        DmemRspValid = 1'b0;
        idle_inputs();
        @(negedge clk);
        check({tag, "_rdata"}, ReadDataW, exp);
        check({tag, "_validw"}, ValidW, 1);
        check({tag, "_memtoreg"}, MemToRegW, 1);
        check({tag, "_aluw"}, ALUResultW, a);
        check({tag, "_regwrite"}, RegWriteW, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_validw_once"}, ValidW, 0);
    endtask

    initial begin
        idle_inputs();
        DmemReqReady = 1'b0; DmemRspValid = 1'b0; DmemRdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", StallM, 0);
        check("rst_reqvalid", DmemReqValid, 0);
        check("rst_validw", ValidW, 0);
        check("rst_wstrb", DmemWstrb, 0);
        rst_n = 1'b1;

        // ADD: non-memory op, latency 1
        @(posedge clk); #1;
        ValidM = 1'b1; ALUResultM = 32'h1234; RdM = 5'd5; RegWriteM = 1'b1;
        @(negedge clk);
        check("add_stall", StallM, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("add_aluw", ALUResultW, 32'h1234);
        check("add_rdw", RdW, 5);
        check("add_regwrite", RegWriteW, 1);
        check("add_validw", ValidW, 1);
        check("add_stall2", StallM, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble_validw", ValidW, 0);
        check("bubble_regwrite", RegWriteW, 0);
        check("bubble_rd_hold", RdW, 5);

        // SB 0xA5 to 0x1003, ready low three cycles
        @(posedge clk); #1;
        ValidM = 1'b1; ALUResultM = 32'h1003; WriteDataM = 32'h1234_56A5; RdM = 5'd9;
        RegWriteM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b000;
        DmemReqReady = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (StallM) stall_cnt++;
            if (c >= 1) begin
                check("sb_reqvalid", DmemReqValid, 1);
                check("sb_addr", DmemAddr, 32'h1000);
                check("sb_wdata", DmemWdata, 32'hA5A5_A5A5);
                check("sb_wstrb", DmemWstrb, 4'b1000);
                check("sb_we", DmemWe, 1);
            end
            @(posedge clk); #1;
            if (c == 3) DmemReqReady = 1'b1;
        end
        DmemReqReady = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("sb_stall_cycles", stall_cnt, 4);
        check("sb_validw", ValidW, 1);
        check("sb_regwrite", RegWriteW, 0);
        check("sb_reqvalid_off", DmemReqValid, 0);
        check("sb_stall_after", StallM, 0);

        run_load("lb",  32'h2001, 3'b000, 32'h0000_8000, 2, 32'hFFFF_FF80);
        run_load("lhu", 32'h2002, 3'b101, 32'hBEEF_0000, 1, 32'h0000_BEEF);
        run_load("lh",  32'h2002, 3'b001, 32'hBEEF_0000, 1, 32'hFFFF_BEEF);
        run_load("lbu", 32'h2003, 3'b100, 32'h8F00_0000, 3, 32'h0000_008F);

`ifdef MISALIGN_EXC_EN
        @(posedge clk); #1;
        drive_load(32'h3002, 3'b010);
        DmemReqReady = 1'b1;
        @(negedge clk);
        check("lwmis_stall", StallM, 0);
        check("lwmis_reqvalid", DmemReqValid, 0);
        @(posedge clk); #1;
        idle_inputs();
        DmemReqReady = 1'b0;
        @(negedge clk);
        check("lwmis_exc", MisalignExcW, 1);
        check("lwmis_regwrite", RegWriteW, 0);
        check("lwmis_validw", ValidW, 1);
`else
        run_load("lwmis", 32'h3002, 3'b010, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
`endif

        // reset while a load sits in RESP
        @(posedge clk); #1;
        drive_load(32'h4000, 3'b010);
        DmemReqReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        DmemReqReady = 1'b0;
        @(negedge clk);
        check("rstld_in_resp", StallM, 1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rstld_stall", StallM, 0);
        check("rstld_aluw", ALUResultW, 0);
        check("rstld_rdataw", ReadDataW, 0);
        check("rstld_addr", DmemAddr, 0);
        check("rstld_rdw", RdW, 0);
        check("rstld_memtoreg", MemToRegW, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        DmemRspValid = 1'b1;
        DmemRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stray_stall", StallM, 0);
            check("stray_validw", ValidW, 0);
            check("stray_rdataw", ReadDataW, 0);
            check("stray_reqvalid", DmemReqValid, 0);
            @(posedge clk); #1;
        end
        DmemRspValid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage. Takes the EX/MEM bundle, runs loads and stores on a valid/ready data-memory port, and does byte/halfword lane steering with sign or zero extension.
- Registers the MEM/WB bundle (ReadDataW, ALUResultW, RdW, RegWriteW, MemToRegW) that drives the writeback mux stage.
- Asserts StallM to the hazard unit while a memory transaction is outstanding.

Parameters:
- XLEN, 32, data and address width. Only 32 is supported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidM  in  1  EX/MEM holds a real instruction
- ALUResultM  in  32  effective address, or ALU result for non-memory ops
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- RegWriteM  in  1  instruction writes rd
- MemToRegM  in  1  writeback selects load data
- MemReadM  in  1  load
- MemWriteM  in  1  store
- Funct3M  in  3  access size and signedness
- StallM  out  1  hold EX/MEM and all upstream stages
- DmemReqValid  out  1  request valid
- DmemReqReady  in  1  memory accepts request
- DmemAddr  out  32  word-aligned address {addr[31:2],2'b00}
- DmemWe  out  1  1 = store
- DmemWdata  out  32  lane-replicated store data
- DmemWstrb  out  4  byte enables
- DmemRspValid  in  1  load data valid
- DmemRdata  in  32  raw load word
- ValidW, ReadDataW (32), ALUResultW (32), RdW (5), RegWriteW, MemToRegW  out  registered MEM/WB bundle

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all outputs 0; any in-flight request dropped and its response ignored. Deassertion takes effect at the next clk edge.
- MemOp = ValidM & (MemReadM | MemWriteM). MemReadM and MemWriteM both high is illegal; treat as a load.
- FSM states:
  - IDLE: no MemOp → W bundle loads EX/MEM on the next edge (latency 1), StallM=0. MemOp → latch address, data, strobes and funct3; go to REQ; StallM=1.
  - REQ: DmemReqValid=1 with Addr, We, Wdata and Wstrb held stable until DmemReqReady. On handshake:
    - Store: StallM=0 that cycle; W bundle loads (RegWriteW=0); return to IDLE.
    - Load: go to RESP, StallM=1.
  - RESP: DmemReqValid=0. Wait for DmemRspValid; in that cycle StallM=0; W loads the extended data; return to IDLE. Responses arriving outside RESP are ignored.
- Minimum latency: store 2 cycles, load 3 cycles; no upper bound.
- StallM is combinational from state, MemOp, DmemReqReady and DmemRspValid. EX/MEM inputs are stable while StallM=1.
- On every stalled cycle the W bundle loads a bubble: ValidW=0, RegWriteW=0, other fields hold.
- ValidM=0 → bubble into W.
- Stores: SB → Wdata={4{b}}, Wstrb=1<<a[1:0]. SH → {2{h}}, Wstrb=a[1]?1100:0011. SW → data, 1111.
- Loads: select byte a[1:0] or half a[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Unknown funct3 behaves as LW/SW.
- For a load, ALUResultW = the address; for a non-memory op, ALUResultW = the ALU result. ReadDataW=0 for non-loads.
- Misaligned (LH/SH with a[0]=1; LW/SW with a[1:0]≠0): handling depends on MISALIGN_EXC_EN.

Optional Feature:
- Macro: MISALIGN_EXC_EN.
- Defined: adds output MisalignExcW (1 bit, registered with the W bundle). A misaligned MemOp issues no memory request, completes in 1 cycle like a non-memory op, sets MisalignExcW=1 and forces RegWriteW=0.
- Undefined: no port. Low address bits beyond the access size are ignored (half uses a[1], word uses neither); the access proceeds normally.

Test Plan:
- Reset mid-load (in RESP) → all outputs 0, StallM=0, later stray DmemRspValid ignored.
- ADD result 0x1234 to rd 5, RegWrite=1 → next cycle ALUResultW=0x1234, RdW=5, RegWriteW=1, StallM never high.
- SB 0xA5 to 0x1003 with ready held low for 3 cycles → DmemAddr=0x1000, Wdata=0xA5A5A5A5, Wstrb=1000, stable until ready; StallM high 4 cycles; RegWriteW=0.
- LB at 0x2001, rdata 0x0000_8000, rsp 2 cycles after accept → ReadDataW=0xFFFF_FF80, MemToRegW=1, ValidW=1 for exactly one cycle.
- LHU at 0x2002, rdata 0xBEEF_0000 → ReadDataW=0x0000_BEEF; LH at the same address → 0xFFFF_BEEF.
- LW at 0x3002 → with MISALIGN_EXC_EN: no DmemReqValid, MisalignExcW=1, RegWriteW=0; without it: DmemAddr=0x3000, normal load.
